// File: rtl/alarm_pkg.sv
// Shared types and helpers for the settable alarm-time field counters.
package alarm_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alarm_btn_repeat.sv
// Hold-to-auto-repeat step generator for one debounced front-panel button.
module alarm_btn_repeat
  import alarm_pkg::*;
#(
  parameter int REPEAT_DELAY = 3,
  parameter int REPEAT_RATE  = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic btn,
  output logic step
);

  localparam int HOLD_W   = cnt_width(REPEAT_DELAY);
  localparam int RATE_W   = cnt_width(REPEAT_RATE);
  localparam int HOLD_TGT = (REPEAT_DELAY >= 2) ? (REPEAT_DELAY - 2) : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TGT);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(REPEAT_RATE - 1);

  rpt_state_e        state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [RATE_W-1:0] rate_cnt_r;
  logic              active_s;

  assign active_s = btn & enable;

  // Step decode: combinational so the step lands on count at the same edge the press is sampled.
  always_comb begin
    step = 1'b0;
    if (active_s) begin
      case (state_r)
        RPT_IDLE:   step = 1'b1;
        RPT_HOLD:   step = (hold_cnt_r == HOLD_LAST);
        RPT_REPEAT: step = (rate_cnt_r == RATE_LAST);
        default:    step = 1'b0;
      endcase
    end else begin
      step = 1'b0;
    end
  end

  // Repeat FSM and its hold/rate counters; release or deselect always returns to idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= RPT_IDLE;
      hold_cnt_r <= HOLD_W'(0);
      rate_cnt_r <= RATE_W'(0);
    end else if (!active_s) begin
      state_r    <= RPT_IDLE;
      hold_cnt_r <= HOLD_W'(0);
      rate_cnt_r <= RATE_W'(0);
    end else begin
      case (state_r)
        RPT_IDLE: begin
          state_r    <= RPT_HOLD;
          hold_cnt_r <= HOLD_W'(0);
        end
        RPT_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= RPT_REPEAT;
            rate_cnt_r <= RATE_W'(0);
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (rate_cnt_r == RATE_LAST) begin
            rate_cnt_r <= RATE_W'(0);
          end else begin
            rate_cnt_r <= rate_cnt_r + RATE_W'(1);
          end
        end
        default: begin
          state_r    <= RPT_IDLE;
          hold_cnt_r <= HOLD_W'(0);
          rate_cnt_r <= RATE_W'(0);
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_field_counter.sv
// One settable alarm-time field: modulo counter with button repeat, direct load and cascade carry.
module alarm_field_counter
  import alarm_pkg::*;
#(
  parameter int MODULUS      = 60,
  parameter int WIDTH        = 6,
  parameter int REPEAT_DELAY = 3,
  parameter int REPEAT_RATE  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             carry_in,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             inc_step_s;
  logic             dec_step_s;
  logic             up_s;
  logic             down_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             carry_nxt_s;
  logic             borrow_nxt_s;

  alarm_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc_rpt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .btn     (btn_inc),
    .step    (inc_step_s)
  );

  alarm_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec_rpt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .btn     (btn_dec),
    .step    (dec_step_s)
  );

  // Next-value selection: load beats cascade carry, which beats a button step; opposing steps cancel.
  always_comb begin
    up_s         = 1'b0;
    down_s       = 1'b0;
    count_nxt_s  = count;
    carry_nxt_s  = 1'b0;
    borrow_nxt_s = 1'b0;
    if (load) begin
      count_nxt_s = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else begin
      up_s   = carry_in | (inc_step_s & ~dec_step_s);
      down_s = ~carry_in & dec_step_s & ~inc_step_s;
      if (up_s) begin
        if (count == MAX_VAL) begin
          count_nxt_s = WIDTH'(0);
          carry_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count + WIDTH'(1);
        end
      end else if (down_s) begin
        if (count == WIDTH'(0)) begin
          count_nxt_s  = MAX_VAL;
          borrow_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count - WIDTH'(1);
        end
      end else begin
        count_nxt_s = count;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count      <= WIDTH'(0);
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      count      <= count_nxt_s;
      carry_out  <= carry_nxt_s;
      borrow_out <= borrow_nxt_s;
    end
  end

endmodule

// File: tb/tb_alarm_field_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_alarm_field_counter;

  localparam int DELAY = 3;
  localparam int RATE  = 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_value = 6'd0;
  logic       carry_in = 1'b0;
  logic [5:0] count60;
  logic       carry60, borrow60;
  logic [4:0] count24;
  logic       carry24, borrow24;

  int checks = 0;
  int failures = 0;

  alarm_field_counter #(.MODULUS(60), .WIDTH(6), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) u_dut60 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .load(load), .load_value(load_value), .carry_in(carry_in),
    .count(count60), .carry_out(carry60), .borrow_out(borrow60));

  alarm_field_counter #(.MODULUS(24), .WIDTH(5), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) u_dut24 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .load(load), .load_value(load_value[4:0]), .carry_in(carry_in),
    .count(count24), .carry_out(carry24), .borrow_out(borrow24));

  always #5 clock = ~clock;

  // Reference model: a press steps on its first cycle, then at hold length DELAY and every RATE after.
  function automatic bit rep_step(input int len);
    return (len == 1) || (len >= DELAY && ((len - DELAY) % RATE) == 0);
  endfunction

  function automatic int nxt_cnt(input int c, input int m, input bit ld, input int lv,
                                 input bit ci, input bit u, input bit d);
    if (ld) return (lv > m - 1) ? m - 1 : lv;
    if (ci || (u && !d)) return (c == m - 1) ? 0 : c + 1;
    if (d && !u) return (c == 0) ? m - 1 : c - 1;
    return c;
  endfunction

  int inc_len = 0, dec_len = 0, ni_s, nd_s;
  bit si_s, sd_s;
  int m60 = 0, m24 = 0;
  bit mc60 = 0, mb60 = 0, mc24 = 0, mb24 = 0;

  assign ni_s = (btn_inc && enable) ? inc_len + 1 : 0;
  assign nd_s = (btn_dec && enable) ? dec_len + 1 : 0;
  assign si_s = rep_step(ni_s);
  assign sd_s = rep_step(nd_s);

  always @(posedge clock) begin
    if (!reset_n) begin
      inc_len <= 0; dec_len <= 0;
      m60 <= 0; mc60 <= 0; mb60 <= 0;
      m24 <= 0; mc24 <= 0; mb24 <= 0;
    end else begin
      inc_len <= ni_s;
      dec_len <= nd_s;
      m60  <= nxt_cnt(m60, 60, load, int'(load_value), carry_in, si_s, sd_s);
      mc60 <= !load && (carry_in || (si_s && !sd_s)) && m60 == 59;
      mb60 <= !load && !carry_in && sd_s && !si_s && m60 == 0;
      m24  <= nxt_cnt(m24, 24, load, int'(load_value[4:0]), carry_in, si_s, sd_s);
      mc24 <= !load && (carry_in || (si_s && !sd_s)) && m24 == 23;
      mb24 <= !load && !carry_in && sd_s && !si_s && m24 == 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = 6'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    reset_n = 1'b1;
    checks++;
    if (count60 !== 6'd0 || carry60 !== 1'b0 || borrow60 !== 1'b0) begin
      failures++; $display("FAIL reset_init: count=%0d carry=%b borrow=%b expected 0 0 0", count60, carry60, borrow60);
    end
    do_load(37);
    checks++;
    if (count60 !== 6'd37) begin failures++; $display("FAIL load37: count=%0d expected 37", count60); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (count60 !== 6'd0 || carry60 !== 1'b0 || borrow60 !== 1'b0) begin
      failures++; $display("FAIL reset_from_37: count=%0d carry=%b borrow=%b expected 0 0 0", count60, carry60, borrow60);
    end
  endtask

  task automatic test_wrap_up();
    enable = 1'b1;
    do_load(58);
    btn_inc = 1'b1; tick();
    checks++;
    if (count60 !== 6'd59 || carry60 !== 1'b0) begin failures++; $display("FAIL tap_58: count=%0d carry=%b expected 59 0", count60, carry60); end
    btn_inc = 1'b0; tick();
    btn_inc = 1'b1; tick();
    checks++;
    if (count60 !== 6'd0 || carry60 !== 1'b1) begin failures++; $display("FAIL tap_59_wrap: count=%0d carry=%b expected 0 1", count60, carry60); end
    btn_inc = 1'b0; tick();
    checks++;
    if (count60 !== 6'd0 || carry60 !== 1'b0) begin failures++; $display("FAIL carry_one_cycle: count=%0d carry=%b expected 0 0", count60, carry60); end
  endtask

  task automatic test_borrow();
    btn_dec = 1'b1; tick();
    checks++;
    if (count60 !== 6'd59 || borrow60 !== 1'b1) begin failures++; $display("FAIL dec_wrap: count=%0d borrow=%b expected 59 1", count60, borrow60); end
    btn_dec = 1'b0; tick();
    checks++;
    if (count60 !== 6'd59 || borrow60 !== 1'b0) begin failures++; $display("FAIL borrow_one_cycle: count=%0d borrow=%b expected 59 0", count60, borrow60); end
  endtask

  task automatic test_hold_repeat();
    int exp_q[$] = '{11, 11, 12, 13, 14, 15};
    do_load(10);
    btn_inc = 1'b1;
    foreach (exp_q[i]) begin
      tick();
      checks++;
      if (int'(count60) != exp_q[i]) begin failures++; $display("FAIL hold_cycle%0d: count=%0d expected %0d", i + 1, count60, exp_q[i]); end
    end
    btn_inc = 1'b0;
    tick(); tick();
    checks++;
    if (count60 !== 6'd15) begin failures++; $display("FAIL hold_release: count=%0d expected 15", count60); end
  endtask

  task automatic test_both_buttons();
    do_load(20);
    btn_inc = 1'b1; btn_dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count60 !== 6'd20 || carry60 !== 1'b0 || borrow60 !== 1'b0) begin
        failures++; $display("FAIL both_btn%0d: count=%0d carry=%b borrow=%b expected 20 0 0", i, count60, carry60, borrow60);
      end
    end
    btn_inc = 1'b0; btn_dec = 1'b0; tick();
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_value = 6'd63; carry_in = 1'b1;
    tick();
    load = 1'b0; carry_in = 1'b0;
    checks++;
    if (count60 !== 6'd59 || carry60 !== 1'b0) begin failures++; $display("FAIL load_clamp_carry: count=%0d carry=%b expected 59 0", count60, carry60); end
  endtask

  task automatic test_enable_off();
    enable = 1'b0; btn_inc = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (count60 !== 6'd59) begin failures++; $display("FAIL enable_off: count=%0d expected 59", count60); end
    btn_inc = 1'b0;
  endtask

  task automatic test_carry_in();
    carry_in = 1'b1; tick();
    carry_in = 1'b0;
    checks++;
    if (count60 !== 6'd0 || carry60 !== 1'b1) begin failures++; $display("FAIL carry_in_wrap: count=%0d carry=%b expected 0 1", count60, carry60); end
    tick();
    checks++;
    if (carry60 !== 1'b0) begin failures++; $display("FAIL carry_in_pulse: carry=%b expected 0", carry60); end
  endtask

  task automatic test_mod24();
    enable = 1'b1;
    do_load(23);
    btn_inc = 1'b1; tick();
    btn_inc = 1'b0;
    checks++;
    if (count24 !== 5'd0 || carry24 !== 1'b1) begin failures++; $display("FAIL mod24_wrap: count=%0d carry=%b expected 0 1", count24, carry24); end
    tick();
    do_load(30);
    checks++;
    if (count24 !== 5'd23) begin failures++; $display("FAIL mod24_clamp: count=%0d expected 23", count24); end
  endtask

  task automatic test_reset_mid_hold();
    int exp_q[$] = '{6, 6, 0, 1, 1, 2};
    enable = 1'b1;
    do_load(5);
    btn_inc = 1'b1;
    foreach (exp_q[i]) begin
      reset_n = (i == 2) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (int'(count60) != exp_q[i]) begin failures++; $display("FAIL reset_mid_hold%0d: count=%0d expected %0d", i, count60, exp_q[i]); end
    end
    reset_n = 1'b1; btn_inc = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset_n    = ($urandom_range(0, 60) != 0);
      enable     = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 7) == 0) btn_dec = ~btn_dec;
      load       = ($urandom_range(0, 14) == 0);
      load_value = 6'($urandom_range(0, 63));
      carry_in   = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (int'(count60) != m60 || carry60 !== mc60 || borrow60 !== mb60) begin
        failures++; $display("FAIL rand60 cyc%0d: count=%0d c=%b b=%b expected %0d %b %b", i, count60, carry60, borrow60, m60, mc60, mb60);
      end
      checks++;
      if (int'(count24) != m24 || carry24 !== mc24 || borrow24 !== mb24) begin
        failures++; $display("FAIL rand24 cyc%0d: count=%0d c=%b b=%b expected %0d %b %b", i, count24, carry24, borrow24, m24, mc24, mb24);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_borrow();
    test_hold_repeat();
    test_both_buttons();
    test_load_priority();
    test_enable_off();
    test_carry_in();
    test_mod24();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
